// File: rtl/gpp_flow_pkg.sv
// Shared types and constants for the control-flow / stack sequencer.
package gpp_flow_pkg;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_JMP  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_PUSH = 3'd4,
    OP_POP  = 3'd5
  } op_code_t;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OVF  = 2'b01;
  localparam logic [1:0] FLT_UNF  = 2'b10;
  localparam logic [1:0] FLT_ILL  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t MEM_WR = 2'd1;
  localparam state_t MEM_RD = 2'd2;

endpackage

// File: rtl/flow_stack_ctrl_sp_bound_check.sv
// Full/empty detection for the descending stack; bounds are only enforced
// when STACK_CHECK_EN is defined, otherwise both flags stay low.
module sp_bound_check #(
  parameter logic [15:0] SP_INIT  = 16'h018F,
  parameter logic [15:0] SP_LIMIT = 16'h0100
) (
  input  logic [15:0] sp,
  output logic        full,
  output logic        empty
);

  logic check_en;

`ifdef STACK_CHECK_EN
  assign check_en = 1'b1;
`else
  assign check_en = 1'b0;
`endif

  assign full  = check_en & (sp == SP_LIMIT - 16'd1);
  assign empty = check_en & (sp == SP_INIT);

endmodule

// File: rtl/flow_stack_ctrl.sv
// PC/SP sequencer executing NEXT/JMP/CALL/RET/PUSH/POP over a req/ack memory port.
// Stack bound faults are built only with STACK_CHECK_EN defined.
module flow_stack_ctrl
  import gpp_flow_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] SP_INIT  = 16'h018F,
  parameter logic [15:0] SP_LIMIT = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [15:0] op_target,
  input  logic [15:0] op_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] pc,
  output logic [15:0] sp,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic        fault,
  output logic [1:0]  fault_code,
  input  logic        fault_clr
);

  state_t      state;
  logic [2:0]  pend_op;
  logic [15:0] pend_target;
  logic        full;
  logic        empty;
  logic        accept;
  logic        mem_done;
  logic [1:0]  op_flt;

  sp_bound_check #(
    .SP_INIT  (SP_INIT),
    .SP_LIMIT (SP_LIMIT)
  ) u_bound (
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

  assign op_ready = (state == IDLE);
  assign accept   = op_valid & op_ready;
  // A late ack with no request outstanding is never a completion.
  assign mem_done = mem_req & mem_ack;

  always_comb begin
    op_flt = FLT_NONE;
    case (op_code)
      OP_NEXT, OP_JMP: op_flt = FLT_NONE;
      OP_CALL, OP_PUSH: if (full)  op_flt = FLT_OVF;
      OP_RET,  OP_POP:  if (empty) op_flt = FLT_UNF;
      default: op_flt = FLT_ILL;
    endcase
  end

  // Operands of a memory op are held here until its ack edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_op     <= op_code;
      pend_target <= op_target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= PC_RESET;
      sp         <= SP_INIT;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      pop_data   <= 16'h0000;
      pop_valid  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      pop_valid <= 1'b0;

      // The first fault code sticks; a clear beats a coincident new fault.
      if (fault_clr) begin
        fault      <= 1'b0;
        fault_code <= FLT_NONE;
      end else if (accept && (op_flt != FLT_NONE) && !fault) begin
        fault      <= 1'b1;
        fault_code <= op_flt;
      end

      case (state)
        IDLE: begin
          if (accept && (op_flt == FLT_NONE)) begin
            case (op_code)
              OP_NEXT: pc <= pc + 16'd1;
              OP_JMP:  pc <= op_target;
              OP_CALL, OP_PUSH: begin
                mem_addr  <= sp;
                mem_wdata <= (op_code == OP_CALL) ? pc + 16'd1 : op_data;
                mem_we    <= 1'b1;
                mem_req   <= 1'b1;
                state     <= MEM_WR;
              end
              OP_RET, OP_POP: begin
                mem_addr <= sp + 16'd1;
                mem_we   <= 1'b0;
                mem_req  <= 1'b1;
                state    <= MEM_RD;
              end
              default: ;
            endcase
          end
        end
        MEM_WR: begin
          if (mem_done) begin
            sp      <= sp - 16'd1;
            mem_req <= 1'b0;
            state   <= IDLE;
            if (pend_op == OP_CALL) pc <= pend_target;
          end
        end
        MEM_RD: begin
          if (mem_done) begin
            sp      <= sp + 16'd1;
            mem_req <= 1'b0;
            state   <= IDLE;
            if (pend_op == OP_RET) begin
              pc <= mem_rdata;
            end else begin
              pop_data  <= mem_rdata;
              pop_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flow_stack_ctrl.sv
// Randomized self-checking bench for flow_stack_ctrl against a stack/queue model.
module tb_flow_stack_ctrl;

  localparam logic [15:0] SP_INIT_V = 16'h018F;
  localparam logic [15:0] SP_LIM    = 16'h018C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic [15:0] op_target = 16'h0000;
  logic [15:0] op_data = 16'h0000;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;
  logic [15:0] pc;
  logic [15:0] sp;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        fault;
  logic [1:0]  fault_code;
  logic        fault_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_sp;
  logic        m_fault;
  logic [1:0]  m_code;
  logic [15:0] m_stack[$];
  logic [15:0] bmem[int];

  flow_stack_ctrl #(
    .PC_RESET (16'h0000),
    .SP_INIT  (SP_INIT_V),
    .SP_LIMIT (SP_LIM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_target  (op_target),
    .op_data    (op_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .pc         (pc),
    .sp         (sp),
    .pop_data   (pop_data),
    .pop_valid  (pop_valid),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_clr  (fault_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pattern(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000;
    m_sp = SP_INIT_V;
    m_fault = 1'b0;
    m_code = 2'b00;
    m_stack.delete();
    bmem.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // Issue one op, service its memory traffic after dly extra cycles, check result.
  task automatic do_op(input logic [2:0] c, input logic [15:0] tgt, input logic [15:0] dat,
                       input int dly, input logic clr, input string nm);
    logic [1:0]  f;
    logic [15:0] exp_addr, exp_wdata, exp_val;
    f = 2'b00;
    if (c > 3'd5) f = 2'b11;
`ifdef STACK_CHECK_EN
    else if ((c == 3'd2 || c == 3'd4) && m_sp == SP_LIM - 16'd1) f = 2'b01;
    else if ((c == 3'd3 || c == 3'd5) && m_sp == SP_INIT_V) f = 2'b10;
`endif
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_before got=%b want=1", nm, op_ready);
    end
    op_valid = 1'b1; op_code = c; op_target = tgt; op_data = dat; fault_clr = clr;
    @(negedge clk);
    op_valid = 1'b0; fault_clr = 1'b0;
    if (clr) begin m_fault = 1'b0; m_code = 2'b00; end
    else if (f != 2'b00 && !m_fault) begin m_fault = 1'b1; m_code = f; end

    if (f != 2'b00 || c == 3'd0 || c == 3'd1) begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL %s no_req got=%b want=0", nm, mem_req);
      end
      if (f == 2'b00 && c == 3'd0) m_pc = m_pc + 16'd1;
      if (f == 2'b00 && c == 3'd1) m_pc = tgt;
    end else begin
      if (c == 3'd2 || c == 3'd4) begin
        exp_addr = m_sp;
        exp_wdata = (c == 3'd2) ? m_pc + 16'd1 : dat;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin
          errors++;
          $display("FAIL %s wr_req got req=%b we=%b addr=%h data=%h want 1 1 %h %h",
                   nm, mem_req, mem_we, mem_addr, mem_wdata, exp_addr, exp_wdata);
        end
      end else begin
        exp_addr = m_sp + 16'd1;
        exp_wdata = 16'h0000;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL %s rd_req got req=%b we=%b addr=%h want 1 0 %h",
                   nm, mem_req, mem_we, mem_addr, exp_addr);
        end
      end
      for (int i = 0; i <= dly; i++) begin
        checks++;
        if (op_ready !== 1'b0 || mem_req !== 1'b1 || mem_addr !== exp_addr) begin
          errors++;
          $display("FAIL %s busy_cycle%0d got ready=%b req=%b addr=%h want 0 1 %h",
                   nm, i, op_ready, mem_req, mem_addr, exp_addr);
        end
        if (i < dly) @(negedge clk);
      end
      if (c == 3'd2 || c == 3'd4) begin
        bmem[int'(mem_addr)] = mem_wdata;
        m_stack.push_back(exp_wdata);
        m_sp = m_sp - 16'd1;
        if (c == 3'd2) m_pc = tgt;
      end else begin
        exp_val = (m_stack.size() > 0) ? m_stack.pop_back() : pattern(exp_addr);
        mem_rdata = bmem.exists(int'(mem_addr)) ? bmem[int'(mem_addr)] : pattern(mem_addr);
        m_sp = m_sp + 16'd1;
        if (c == 3'd3) m_pc = exp_val;
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 16'($urandom);
      if (c == 3'd5) begin
        checks++;
        if (pop_valid !== 1'b1 || pop_data !== exp_val) begin
          errors++;
          $display("FAIL %s pop got valid=%b data=%h want 1 %h", nm, pop_valid, pop_data, exp_val);
        end
      end
    end
    if (!(c == 3'd5 && f == 2'b00)) begin
      checks++;
      if (pop_valid !== 1'b0) begin
        errors++; $display("FAIL %s pop_valid_idle got=%b want=0", nm, pop_valid);
      end
    end
    checks++;
    if (pc !== m_pc || sp !== m_sp || fault !== m_fault || fault_code !== m_code || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s state got pc=%h sp=%h fault=%b code=%b ready=%b want %h %h %b %b 1",
               nm, pc, sp, fault, fault_code, op_ready, m_pc, m_sp, m_fault, m_code);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pc !== 16'h0000 || sp !== SP_INIT_V || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 16'h0000 || mem_wdata !== 16'h0000 || pop_data !== 16'h0000 ||
        pop_valid !== 1'b0 || fault !== 1'b0 || fault_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_values got pc=%h sp=%h req=%b we=%b addr=%h wd=%h pd=%h pv=%b f=%b fc=%b",
               pc, sp, mem_req, mem_we, mem_addr, mem_wdata, pop_data, pop_valid, fault, fault_code);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b want=1", op_ready);
    end
  endtask

  task automatic test_next();
    for (int i = 0; i < 3; i++) do_op(3'd0, 16'h0000, 16'h0000, 0, 1'b0, "next");
    checks++;
    if (pc !== 16'h0003 || sp !== 16'h018F) begin
      errors++; $display("FAIL next_three got pc=%h sp=%h want 0003 018f", pc, sp);
    end
    do_op(3'd1, 16'hFFFF, 16'h0000, 0, 1'b0, "jmp_ffff");
    do_op(3'd0, 16'h0000, 16'h0000, 0, 1'b0, "next_wrap");
    checks++;
    if (pc !== 16'h0000) begin
      errors++; $display("FAIL next_wrap_pc got=%h want=0000", pc);
    end
  endtask

  task automatic test_call_ret();
    do_op(3'd1, 16'h0010, 16'h0000, 0, 1'b0, "jmp_0010");
    do_op(3'd2, 16'h0200, 16'h0000, 2, 1'b0, "call");
    checks++;
    if (pc !== 16'h0200 || sp !== 16'h018E || bmem[16'h018F] !== 16'h0011) begin
      errors++; $display("FAIL call_result got pc=%h sp=%h mem=%h want 0200 018e 0011",
                         pc, sp, bmem[16'h018F]);
    end
    do_op(3'd3, 16'h0000, 16'h0000, 0, 1'b0, "ret");
    checks++;
    if (pc !== 16'h0011 || sp !== 16'h018F) begin
      errors++; $display("FAIL ret_result got pc=%h sp=%h want 0011 018f", pc, sp);
    end
  endtask

  task automatic test_faults();
    for (int i = 0; i < 4; i++) do_op(3'd4, 16'h0000, 16'(16'hC000 + i), $urandom_range(0, 2), 1'b0, "push_ok");
    checks++;
    if (sp !== 16'h018B || fault !== 1'b0) begin
      errors++; $display("FAIL push_four got sp=%h fault=%b want 018b 0", sp, fault);
    end
    do_op(3'd4, 16'h0000, 16'hBEEF, 0, 1'b0, "push_full");
`ifdef STACK_CHECK_EN
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || sp !== 16'h018B) begin
      errors++; $display("FAIL overflow got fault=%b code=%b sp=%h want 1 01 018b", fault, fault_code, sp);
    end
`endif
    do_op(3'd0, 16'h0000, 16'h0000, 0, 1'b1, "clr1");
    while (m_sp != SP_INIT_V) do_op(3'd5, 16'h0000, 16'h0000, $urandom_range(0, 3), 1'b0, "pop_drain");
    do_op(3'd5, 16'h0000, 16'h0000, 1, 1'b0, "pop_empty");
`ifdef STACK_CHECK_EN
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10) begin
      errors++; $display("FAIL underflow got fault=%b code=%b want 1 10", fault, fault_code);
    end
`endif
    do_op(3'd0, 16'h0000, 16'h0000, 0, 1'b1, "clr2");
    do_op(3'd7, 16'h1234, 16'h0000, 0, 1'b0, "illegal7");
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b11) begin
      errors++; $display("FAIL illegal got fault=%b code=%b want 1 11", fault, fault_code);
    end
    do_op(3'd0, 16'h0000, 16'h0000, 0, 1'b1, "clr3");
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00) begin
      errors++; $display("FAIL fault_clr got fault=%b code=%b want 0 00", fault, fault_code);
    end
    do_op(3'd6, 16'h0000, 16'h0000, 0, 1'b1, "illegal_with_clr");
  endtask

  task automatic test_random();
    logic [2:0] c;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      c = 3'($urandom_range(0, 7));
      do_op(c, 16'($urandom), 16'($urandom), $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0), "random");
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset_midreq();
    apply_reset();
    op_valid = 1'b1; op_code = 3'd2; op_target = 16'h0300;
    @(negedge clk);
    op_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL midreq_req got=%b want=1", mem_req);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || pc !== 16'h0000 || sp !== SP_INIT_V) begin
      errors++; $display("FAIL midreq_async got req=%b pc=%h sp=%h want 0 0000 018f", mem_req, pc, sp);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || pc !== 16'h0000 || sp !== SP_INIT_V || op_ready !== 1'b1 || pop_valid !== 1'b0) begin
      errors++; $display("FAIL stray_ack got req=%b pc=%h sp=%h ready=%b pv=%b want 0 0000 018f 1 0",
                         mem_req, pc, sp, op_ready, pop_valid);
    end
    do_op(3'd0, 16'h0000, 16'h0000, 0, 1'b0, "after_reset_next");
  endtask

  initial begin
    test_reset();
    test_next();
    test_call_ret();
    test_faults();
    test_random();
    test_reset_midreq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flow_stack_ctrl.md
Name: flow_stack_ctrl

Overview:
Sequencer that owns the program counter and stack pointer and executes control-flow and stack operations: NEXT, JMP, CALL, RET, PUSH and POP.
It sits between instruction decode (valid/ready op interface) and the shared data-memory port (req/ack handshake).
CALL, RET, PUSH and POP spend memory cycles to save or restore values on a full-descending stack.
It replaces ad-hoc save_* strobes with one arbitrated sequence per op.

Parameters:
PC_RESET, 16'h0000, PC value after reset.
SP_INIT, 16'h018F, SP after reset; the stack is empty when SP == SP_INIT.
SP_LIMIT, 16'h0100, lowest legal stack slot; the stack is full when SP == SP_LIMIT-1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low.
op_valid  in  1  decode presents an op.
op_ready  out  1  controller accepts an op; high only in IDLE.
op_code  in  3  0 NEXT, 1 JMP, 2 CALL, 3 RET, 4 PUSH, 5 POP, 6-7 illegal.
op_target  in  16  jump/call destination.
op_data  in  16  PUSH payload.
mem_req  out  1  memory request, registered.
mem_we  out  1  1 = write, 0 = read.
mem_addr  out  16  memory address.
mem_wdata  out  16  write data.
mem_rdata  in  16  read data, valid with mem_ack.
mem_ack  in  1  completes the current request.
pc  out  16  current PC.
sp  out  16  current SP.
pop_data  out  16  value returned by POP.
pop_valid  out  1  one-cycle pulse when pop_data updates.
fault  out  1  sticky error flag.
fault_code  out  2  01 overflow, 10 underflow, 11 illegal op.
fault_clr  in  1  synchronous clear of fault and fault_code.

Behaviour:
- Reset (asynchronous, any state, including mid-request):
  - pc=PC_RESET, sp=SP_INIT, state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - pop_data=0, pop_valid=0, fault=0, fault_code=0.
  - op_ready=1 once reset deasserts.
  - An in-flight memory request is abandoned; a late mem_ack is ignored.
- States: IDLE, MEM_WR, MEM_RD. An op is accepted on an edge where op_valid & op_ready.
- NEXT: pc<=pc+1 at the accept edge, modulo 2^16 (0xFFFF wraps to 0x0000). Stays IDLE; 1 op/cycle throughput.
- JMP: pc<=op_target at the accept edge. Stays IDLE.
- CALL:
  - Accept edge: mem_addr<=sp, mem_wdata<=pc+1, mem_we<=1, mem_req<=1, go to MEM_WR.
  - On the mem_ack edge: sp<=sp-1, pc<=op_target (latched at accept), mem_req<=0, go to IDLE.
- PUSH: same as CALL with mem_wdata=op_data; pc unchanged.
- RET:
  - Accept edge: mem_addr<=sp+1, mem_we<=0, mem_req<=1, go to MEM_RD.
  - On the mem_ack edge: pc<=mem_rdata, sp<=sp+1.
- POP: same as RET, but on ack pop_data<=mem_rdata and pop_valid=1 for one cycle; pc unchanged.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack edge.
  - Ack may arrive in the first req cycle, giving a minimum 2-cycle memory op.
  - mem_ack is ignored while mem_req=0.
  - op_ready=0 in MEM_WR/MEM_RD; ready returns the cycle after ack.
- Faults:
  - Overflow: CALL/PUSH accepted with sp == SP_LIMIT-1.
  - Underflow: RET/POP accepted with sp == SP_INIT.
  - Illegal: op_code 6 or 7.
  - A faulting op is consumed: no pc/sp change and no memory request; fault=1 and fault_code is set.
  - The first fault code is held until fault_clr or reset. fault_clr wins over a same-cycle new fault.
  - Ops continue to be accepted while fault=1.
- sp arithmetic is 16-bit modulo. Overflow and underflow checks compare exact equality.

Optional Feature:
STACK_CHECK_EN.
- Defined: overflow/underflow detection as above.
- Undefined: SP wraps freely with no bound faults; only illegal-op faults remain, and SP_LIMIT is unused.

Decomposition:
- Package gpp_flow_pkg:
  - op_code enum (OP_NEXT..OP_POP).
  - Fault code constants FLT_NONE/OVF/UNF/ILL.
  - State enum IDLE/MEM_WR/MEM_RD.
- One sub-module, sp_bound_check: combinational full/empty detect from sp, SP_INIT and SP_LIMIT, gated by STACK_CHECK_EN.

Test Plan:
- Reset, then 3 NEXT ops on consecutive cycles -> pc 0x0000 to 0x0003, sp 0x018F, op_ready held 1.
- pc=0x0010, CALL target 0x0200, ack after 2 cycles:
  - mem write addr 0x018F, data 0x0011.
  - Then pc=0x0200, sp=0x018E; op_ready low for 3 cycles.
- RET with mem_rdata 0x0011 and immediate ack -> read addr 0x018F, pc=0x0011, sp=0x018F.
- SP_LIMIT=0x018C: 4 PUSH ok, sp=0x018B; 5th PUSH -> fault=1, code 01, no mem_req, sp unchanged.
- POP on empty stack -> fault code 10.
- op_code 7 -> fault code 11; fault_clr -> fault=0.
- Reset asserted while mem_req=1 awaiting ack -> mem_req drops immediately, pc=0, sp=0x018F; a subsequent stray mem_ack has no effect.
